i2s_rx_arbiter: RTL and testbench
=================================

# i2s_rx_arbiter

- Round-robin, packet-locked arbiter that merges the CN per-channel I2S receive streams into one AXI-stream for the packetizer/uplink.
- Sits after the per-channel clock-domain-crossing FIFOs, so all inputs are already in the `clk` domain.
- Grants one channel at a time and holds the grant until that channel's `tlast` (one TDM frame).
- Tags each output beat with the source channel index and the channel's destination FPGA index.

## Interface
Parameters:
- `CN`, 16, number of I2S channels (2..16).
- `DW`, 32, sample width per beat.
- `TIMEOUT`, 1024, stall cycles before a locked grant is forcibly released (used only with the macro).

Ports (`IW` = max(1, clog2(CN))):
- `clk`  in  1  system clock; sole clock of the block.
- `arst_n`  in  1  reset; asynchronous assert, active-low.
- `s_axis_tvalid`  in  CN  per-channel valid.
- `s_axis_tready`  out  CN  per-channel ready.
- `s_axis_tdata`  in  DW*CN  per-channel sample; channel i is at `[DW*i +: DW]`.
- `s_axis_tlast`  in  CN  per-channel end of TDM frame.
- `i_dst_fpga_index`  in  4*CN  per-channel destination index.
- `i_enable`  in  CN  channel eligible for a new grant.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  output ready.
- `m_axis_tdata`  out  DW  output sample.
- `m_axis_tlast`  out  1  output end of frame.
- `m_axis_tid`  out  IW  source channel index.
- `m_axis_tdest`  out  4  destination FPGA index, latched at grant.
- `o_busy`  out  1  FSM is in GRANT.
- `o_timeout_cnt`  out  16  saturating count of forced releases.

## Operation
- **FSM states:** IDLE and GRANT.
- **Eligible channel:** `s_axis_tvalid[i] & i_enable[i]`.
- **IDLE:**
  - Scan the eligible channels in rotated order, starting at `ptr`.
  - Take the first hit `g` and register `gnt = g`.
  - Latch `tdest = i_dst_fpga_index[4*g +: 4]`.
  - Go to GRANT.
  - No eligible channel: stay in IDLE.
- **GRANT:**
  - `s_axis_tready[gnt] = ~m_axis_tvalid | m_axis_tready`.
  - Every other bit of `s_axis_tready` is 0.
  - An accepted beat loads the output register: data, last, `tid = gnt`, `tdest`.
  - An accepted beat with `tlast` returns to IDLE and sets `ptr = (gnt == CN-1) ? 0 : gnt+1`.
- **Output register:**
  - Single stage.
  - `m_axis_tvalid` clears on `m_axis_tready` unless a new beat loads in the same cycle.
  - Back-to-back throughput is 1 beat/cycle while the output is ready.
- **Enable changes:**
  - Deasserting `i_enable[gnt]` mid-frame does not break the grant; the frame completes.
  - `i_enable` is sampled only in IDLE.
- **Simultaneous requests:** rotation guarantees each eligible channel is served within CN frames.
- **Reset:**
  - `arst_n` low forces IDLE, `ptr=0`, `gnt=0`, `m_axis_tvalid=0`, `m_axis_tlast=0`.
  - All data/tid/tdest registers, `s_axis_tready`, `o_busy` and `o_timeout_cnt` are 0.
  - A frame in flight is discarded; there is no partial output after reset release.

## Timing
- Request visible in IDLE at cycle 0 → GRANT and `s_axis_tready` high at cycle 1 → `m_axis_tvalid` at cycle 2.
- Arbitration overhead is 1 idle cycle per frame: IDLE is visited once between frames, including the re-grant of the same channel.
- `o_busy` is high exactly during GRANT cycles.
- The combinational path from `m_axis_tready` to `s_axis_tready` is intentional; no path exists from `s_axis_tvalid` to `m_axis_*`.

## Configuration
- **Macro:** `I2S_ARB_TIMEOUT_EN`.
- **Defined:**
  - In GRANT, a 16-bit counter increments on every cycle with `s_axis_tvalid[gnt]=0`.
  - The counter clears on any accepted beat and on entry to GRANT.
  - When it reaches `TIMEOUT`, the FSM returns to IDLE and sets `ptr = gnt+1` (wrapped).
  - `o_timeout_cnt` increments, saturating at 0xFFFF.
  - The downstream sees a truncated frame with no `tlast`; it must handle this.
- **Undefined:**
  - No counter is built.
  - The grant is held indefinitely until `tlast`.
  - `o_timeout_cnt` is constant 0.

## Test plan
- **Reset and single frame:** release reset, then ch3 sends 8 beats (`tlast` on the 8th) with output always ready. Required: 8 output beats with `tid=3` and `tdest = i_dst_fpga_index[15:12]`; first `m_axis_tvalid` 2 cycles after `tvalid`; `o_busy` low after the last beat.
- **Round-robin fairness:** ch0, ch1 and ch5 all continuously valid with 4-beat frames. Required: `tid` frame sequence 0,1,5,0,1,5; one idle cycle between frames.
- **Backpressure:** `m_axis_tready` toggles 1010… during a 6-beat frame. Required: no lost or duplicated beats; data order preserved; `s_axis_tready[gnt]` low in every cycle where output is valid and not ready.
- **Enable:**
  - `i_enable[2]=0` while ch2 is valid → ch2 is never granted.
  - Clearing `i_enable[1]` after ch1's 2nd beat → ch1's frame still completes with `tlast`.
- **Timeout (macro defined, `TIMEOUT=16`):** ch4 sends 2 beats, then holds `tvalid=0` for 16 cycles. Required: `o_busy` falls; `o_timeout_cnt=1`; ch5 (valid) is granted next.
- **Reset mid-frame:** assert `arst_n=0` after beat 3 of 8. Required: all outputs 0 immediately; after release, the next output frame starts with the new grant from `ptr=0`.

Source files
------------

// File: rtl/i2s_rx_arbiter.sv
// i2s_rx_arbiter: round-robin, frame-locked merge of CN per-channel I2S sample streams into one AXI-stream.
// Latency: request seen in IDLE -> s_axis_tready next cycle -> m_axis_tvalid the cycle after; one idle cycle per frame.
// Backpressure: only the granted channel sees tready (= ~m_axis_tvalid | m_axis_tready); optional stall watchdog under `I2S_ARB_TIMEOUT_EN.
module i2s_rx_arbiter #(
  parameter int CN      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024,
  localparam int IW     = (CN > 1) ? $clog2(CN) : 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [CN-1:0]     s_axis_tvalid,
  output logic [CN-1:0]     s_axis_tready,
  input  logic [DW*CN-1:0]  s_axis_tdata,
  input  logic [CN-1:0]     s_axis_tlast,
  input  logic [4*CN-1:0]   i_dst_fpga_index,
  input  logic [CN-1:0]     i_enable,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DW-1:0]     m_axis_tdata,
  output logic              m_axis_tlast,
  output logic [IW-1:0]     m_axis_tid,
  output logic [3:0]        m_axis_tdest,
  output logic              o_busy,
  output logic [15:0]       o_timeout_cnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [3:0]    tdest_q, tdest_d;

  logic          m_vld_q;
  logic [DW-1:0] m_dat_q;
  logic          m_last_q;
  logic [IW-1:0] m_tid_q;
  logic [3:0]    m_dest_q;

  logic [CN-1:0] elig;
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic          busy;
  logic          out_rdy;
  logic          cur_vld;
  logic          cur_last;
  logic          accept;
  logic [IW-1:0] nxt_ptr;
  logic          to_fire;

  // Channel index k positions after base, wrapped at CN.
  function automatic logic [IW-1:0] rot(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= CN) s = s - CN;
    return IW'(s);
  endfunction

  assign elig     = s_axis_tvalid & i_enable;
  assign busy     = (state_q == ST_GRANT);
  // Output register can take a beat when empty or draining this cycle.
  assign out_rdy  = ~m_vld_q | m_axis_tready;
  assign cur_vld  = s_axis_tvalid[gnt_q];
  assign cur_last = s_axis_tlast[gnt_q];
  assign accept   = busy & cur_vld & out_rdy;
  assign nxt_ptr  = (gnt_q == IW'(CN - 1)) ? '0 : gnt_q + IW'(1);

  // Rotated priority scan: walk backwards so the entry closest to ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = CN - 1; k >= 0; k--) begin
      if (elig[rot(ptr_q, k)]) begin
        pick_vld = 1'b1;
        pick_idx = rot(ptr_q, k);
      end
    end
  end

  // Only the granted channel is offered ready; enables are ignored once locked.
  always_comb begin
    s_axis_tready = '0;
    if (busy) s_axis_tready[gnt_q] = out_rdy;
  end

  // Grant FSM: lock on a channel until its tlast (or a watchdog release).
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    tdest_d = tdest_q;
    if (state_q == ST_IDLE) begin
      if (pick_vld) begin
        state_d = ST_GRANT;
        gnt_d   = pick_idx;
        tdest_d = i_dst_fpga_index[int'(pick_idx)*4 +: 4];
      end
    end else begin
      if ((accept && cur_last) || to_fire) begin
        state_d = ST_IDLE;
        ptr_d   = nxt_ptr;
      end
    end
  end

  // FSM and grant bookkeeping registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      tdest_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      tdest_q <= tdest_d;
    end
  end

  // Single-stage output register; holds its beat until the sink takes it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_vld_q  <= 1'b0;
      m_dat_q  <= '0;
      m_last_q <= 1'b0;
      m_tid_q  <= '0;
      m_dest_q <= '0;
    end else if (accept) begin
      m_vld_q  <= 1'b1;
      m_dat_q  <= s_axis_tdata[int'(gnt_q)*DW +: DW];
      m_last_q <= cur_last;
      m_tid_q  <= gnt_q;
      m_dest_q <= tdest_q;
    end else if (m_axis_tready) begin
      m_vld_q  <= 1'b0;
    end
  end

`ifdef I2S_ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [15:0] to_tot_q;
  logic        stall;

  // A stall is a granted cycle where the locked channel has nothing to offer.
  assign stall   = busy & ~cur_vld;
  assign to_fire = stall & (to_cnt_q == 16'(TIMEOUT - 1));

  // Stall counter restarts on every grant and on every accepted beat.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!busy || accept) to_cnt_d = '0;
    else if (stall)      to_cnt_d = to_cnt_q + 16'd1;
  end

  // Stall counter and saturating forced-release tally.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      to_cnt_q <= '0;
      to_tot_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
      if (to_fire && (to_tot_q != 16'hFFFF)) to_tot_q <= to_tot_q + 16'd1;
    end
  end

  assign o_timeout_cnt = to_tot_q;
`else
  // Without the watchdog a grant is held until tlast; TIMEOUT has no effect.
  assign to_fire       = 1'b0;
  assign o_timeout_cnt = 16'(TIMEOUT) & 16'h0000;
`endif

  assign m_axis_tvalid = m_vld_q;
  assign m_axis_tdata  = m_dat_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tid    = m_tid_q;
  assign m_axis_tdest  = m_dest_q;
  assign o_busy        = busy;

endmodule

// File: tb/tb_i2s_rx_arbiter.sv
// tb_i2s_rx_arbiter: directed bench for i2s_rx_arbiter with CN=8, TIMEOUT=16.
// Bench-side sources emit data {ch, frame, beat}; a monitor logs every output handshake.
// Expected values are hand-derived from the arbitration rules.
module tb_i2s_rx_arbiter;
  localparam int CN = 8;
  localparam int DW = 32;
  localparam int IW = 3;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic [CN-1:0]     s_axis_tvalid, s_axis_tready, s_axis_tlast, i_enable;
  logic [DW*CN-1:0]  s_axis_tdata;
  logic [4*CN-1:0]   i_dst_fpga_index;
  logic              m_axis_tvalid, m_axis_tready, m_axis_tlast, o_busy;
  logic [DW-1:0]     m_axis_tdata;
  logic [IW-1:0]     m_axis_tid;
  logic [3:0]        m_axis_tdest;
  logic [15:0]       o_timeout_cnt;

  i2s_rx_arbiter #(.CN(CN), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .arst_n(arst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .i_dst_fpga_index(i_dst_fpga_index), .i_enable(i_enable),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
    .o_busy(o_busy), .o_timeout_cnt(o_timeout_cnt)
  );

  always #5 clk = ~clk;

  // Source control (written by the stimulus) and source progress (written by the source process).
  int          src_len [CN];
  int          src_req [CN];
  int          src_beat[CN];
  int          src_done[CN];
  logic [CN-1:0] src_pause;
  logic        src_clr;

  always_comb begin
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    for (int i = 0; i < CN; i++) begin
      s_axis_tvalid[i]         = (src_done[i] < src_req[i]) && !src_pause[i];
      s_axis_tlast[i]          = (src_beat[i] == src_len[i] - 1);
      s_axis_tdata[DW*i +: DW] = {8'(i), 8'(src_done[i]), 16'(src_beat[i])};
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < CN; i++) begin
      if (src_clr) begin
        src_beat[i] <= 0;
        src_done[i] <= 0;
      end else if (s_axis_tvalid[i] && s_axis_tready[i]) begin
        if (src_beat[i] == src_len[i] - 1) begin
          src_beat[i] <= 0;
          src_done[i] <= src_done[i] + 1;
        end else begin
          src_beat[i] <= src_beat[i] + 1;
        end
      end
    end
  end

  // Output monitor.
  int            cyc = 0;
  int            mon_n = 0;
  int            viol = 0;
  logic [31:0]   mon_dat [256];
  logic          mon_last[256];
  logic [IW-1:0] mon_tid [256];
  logic [3:0]    mon_dest[256];
  int            mon_cyc [256];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_axis_tvalid && m_axis_tready && mon_n < 256) begin
      mon_dat[mon_n]  <= m_axis_tdata;
      mon_last[mon_n] <= m_axis_tlast;
      mon_tid[mon_n]  <= m_axis_tid;
      mon_dest[mon_n] <= m_axis_tdest;
      mon_cyc[mon_n]  <= cyc;
      mon_n           <= mon_n + 1;
    end
    if (m_axis_tvalid && !m_axis_tready && (s_axis_tready != '0)) viol <= viol + 1;
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_mon(input int target, input string tag);
    int n;
    n = 0;
    while (mon_n < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(mon_n >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    int exp_seq[6];
    exp_seq = '{0, 1, 5, 0, 1, 5};

    m_axis_tready    = 1'b1;
    i_enable         = '1;
    i_dst_fpga_index = 32'h0FED_CBA9;   // ch i -> (i+9) mod 16
    src_pause        = '0;
    src_clr          = 1'b1;
    for (int i = 0; i < CN; i++) begin
      src_len[i] = 8;
      src_req[i] = 0;
    end

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast",  32'(m_axis_tlast),  32'd0);
    chk("rst_tdata",  m_axis_tdata,       32'd0);
    chk("rst_tid",    32'(m_axis_tid),    32'd0);
    chk("rst_tdest",  32'(m_axis_tdest),  32'd0);
    chk("rst_busy",   32'(o_busy),        32'd0);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_tocnt",  32'(o_timeout_cnt), 32'd0);
    arst_n  = 1'b1;
    src_clr = 1'b0;
    @(negedge clk);

    // ---- single 8-beat frame from ch3 ----
    src_req[3] = 1;                      // cycle 0: request visible
    @(negedge clk);                      // cycle 1: GRANT, tready
    chk("t1_busy_c1",   32'(o_busy),        32'd1);
    chk("t1_tready_c1", 32'(s_axis_tready), 32'h08);
    chk("t1_mvld_c1",   32'(m_axis_tvalid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);                    // cycle 2+k: beat k on output
      chk("t1_mvld",  32'(m_axis_tvalid), 32'd1);
      chk("t1_tid",   32'(m_axis_tid),    32'd3);
      chk("t1_tdest", 32'(m_axis_tdest),  32'hC);
      chk("t1_tdata", m_axis_tdata,       {8'd3, 8'd0, 16'(k)});
      chk("t1_tlast", 32'(m_axis_tlast),  32'(k == 7));
    end
    chk("t1_busy_end", 32'(o_busy), 32'd0);
    @(negedge clk);
    chk("t1_mvld_end", 32'(m_axis_tvalid), 32'd0);

    // ---- round robin over ch0, ch1, ch5 from ptr=0 ----
    arst_n  = 1'b0;
    src_clr = 1'b1;
    for (int i = 0; i < CN; i++) src_req[i] = 0;
    src_len[0] = 4; src_len[1] = 4; src_len[5] = 4;
    repeat (2) @(negedge clk);
    arst_n  = 1'b1;
    src_clr = 1'b0;
    @(negedge clk);
    base = mon_n;
    src_req[0] = 2; src_req[1] = 2; src_req[5] = 2;
    wait_mon(base + 24, "t2_wait");
    for (int f = 0; f < 6; f++) begin
      chk("t2_tid",   32'(mon_tid[base + 4*f]),      32'(exp_seq[f]));
      chk("t2_first", mon_dat[base + 4*f],           {8'(exp_seq[f]), 8'(f / 3), 16'd0});
      chk("t2_last",  32'(mon_last[base + 4*f + 3]), 32'd1);
      chk("t2_burst", 32'(mon_cyc[base + 4*f + 3] - mon_cyc[base + 4*f]), 32'd3);
      if (f < 5) chk("t2_gap", 32'(mon_cyc[base + 4*f + 4] - mon_cyc[base + 4*f + 3]), 32'd2);
    end

    // ---- backpressure on a 6-beat frame from ch6 ----
    src_len[6] = 6;
    base = mon_n;
    src_req[6] = 1;
    for (int c = 0; c < 30; c++) begin
      m_axis_tready = (c % 2 == 0);
      @(negedge clk);
    end
    m_axis_tready = 1'b1;
    wait_mon(base + 6, "t3_wait");
    repeat (5) @(negedge clk);
    chk("t3_count", 32'(mon_n - base), 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk("t3_tdata", mon_dat[base + k],       {8'd6, 8'd0, 16'(k)});
      chk("t3_tlast", 32'(mon_last[base + k]), 32'(k == 5));
    end
    chk("t3_stretched", 32'((mon_cyc[base + 5] - mon_cyc[base]) > 5), 32'd1);
    chk("t3_tready_hold", 32'(viol), 32'd0);

    // ---- enable handling: ch2 masked, ch1 loses enable mid-frame ----
    i_enable[2] = 1'b0;
    src_len[1] = 4; src_len[2] = 4;
    base = mon_n;
    src_req[2] = src_done[2] + 1;
    src_req[1] = src_done[1] + 1;
    n = 0;
    while (src_beat[1] != 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_ch1_two_beats", 32'(src_beat[1]), 32'd2);
    i_enable[1] = 1'b0;
    wait_mon(base + 4, "t4_wait_ch1");
    for (int k = 0; k < 4; k++) chk("t4_tid_ch1", 32'(mon_tid[base + k]), 32'd1);
    chk("t4_last_ch1", 32'(mon_last[base + 3]), 32'd1);
    repeat (10) @(negedge clk);
    chk("t4_ch2_blocked", 32'(mon_n - base), 32'd4);
    chk("t4_idle",        32'(o_busy),       32'd0);
    i_enable[2] = 1'b1;
    wait_mon(base + 8, "t4_wait_ch2");
    chk("t4_tid_ch2", 32'(mon_tid[base + 4]), 32'd2);
    i_enable = '1;

`ifdef I2S_ARB_TIMEOUT_EN
    // ---- watchdog: ch4 stalls after 2 beats, ch5 waiting ----
    src_len[4] = 8; src_len[5] = 4;
    base = mon_n;
    src_req[4] = src_done[4] + 1;
    src_req[5] = src_done[5] + 1;
    n = 0;
    while (src_beat[4] != 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    src_pause[4] = 1'b1;
    n = 0;
    while (o_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t5_release_cycles", 32'(n), 32'd16);
    chk("t5_tocnt", 32'(o_timeout_cnt), 32'd1);
    wait_mon(base + 6, "t5_wait");
    chk("t5_tid_ch4",   32'(mon_tid[base + 1]),  32'd4);
    chk("t5_no_tlast",  32'(mon_last[base + 1]), 32'd0);
    chk("t5_next_ch5",  32'(mon_tid[base + 2]),  32'd5);
`else
    chk("t5_tocnt_zero", 32'(o_timeout_cnt), 32'd0);
`endif

    // ---- reset in the middle of a ch7 frame ----
    src_len[7] = 8;
    base = mon_n;
    src_req[7] = src_done[7] + 1;
    wait_mon(base + 3, "t6_wait_ch7");
    arst_n  = 1'b0;
    src_clr = 1'b1;
    base = mon_n;
    #1;
    chk("t6_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t6_tlast",  32'(m_axis_tlast),  32'd0);
    chk("t6_tdata",  m_axis_tdata,       32'd0);
    chk("t6_tid",    32'(m_axis_tid),    32'd0);
    chk("t6_tdest",  32'(m_axis_tdest),  32'd0);
    chk("t6_busy",   32'(o_busy),        32'd0);
    chk("t6_tready", 32'(s_axis_tready), 32'd0);
    chk("t6_tocnt",  32'(o_timeout_cnt), 32'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < CN; i++) src_req[i] = 0;
    src_pause = '0;
    src_len[2] = 4; src_len[6] = 4;
    src_req[2] = 1; src_req[6] = 1;
    arst_n  = 1'b1;
    src_clr = 1'b0;
    wait_mon(base + 4, "t6_wait_new");
    chk("t6_new_tid",   32'(mon_tid[base]),  32'd2);
    chk("t6_new_tdata", mon_dat[base],       {8'd2, 8'd0, 16'd0});
    chk("t6_new_tdest", 32'(mon_dest[base]), 32'hB);
    chk("t6_new_last",  32'(mon_last[base + 3]), 32'd1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
